// File: rtl/csr_counter_pkg.sv
// ----------------------------------------------------------------------------
// csr_counter_pkg
// Shared definitions for the counter/CSR bank:
//   - CSR address constants for user (read-only) and machine (read/write)
//     counter views, the high-half offset and mcountinhibit
//   - csr_op_e : CSR operation encoding issued by the decoder
//   - csr_sel_e: internal classification of a decoded CSR address
//   - mcountinhibit bit positions
//   - csr_apply_op: computes the new 32-bit value for RW/RS/RC
// ----------------------------------------------------------------------------
package csr_counter_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        SEL_CNT,
        SEL_TIME,
        SEL_INH
    } csr_sel_e;

    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_TIME          = 12'hC01;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_HPM_BASE      = 12'hC03;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPM_BASE     = 12'hB03;
    localparam logic [11:0] CSR_HI_OFFSET     = 12'h080;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    localparam int INH_CY       = 0;
    localparam int INH_IR       = 2;
    localparam int INH_HPM_BASE = 3;

    function automatic logic [31:0] csr_apply_op(
        input csr_op_e     op,
        input logic [31:0] old_val,
        input logic [31:0] wdata
    );
        case (op)
            CSR_OP_RW: return wdata;
            CSR_OP_RS: return old_val | wdata;
            CSR_OP_RC: return old_val & ~wdata;
            default:   return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter_bank_if.sv
// ----------------------------------------------------------------------------
// csr_counter_bank_if
// Request/response channel between the instruction decoder (master) and the
// counter bank (slave). One request per cycle, registered response one cycle
// later, no backpressure.
//   csr_valid/csr_addr/csr_op/csr_wdata : request, driven by the master
//   csr_ready/csr_rdata/csr_illegal     : response, driven by the slave
// ----------------------------------------------------------------------------
interface csr_counter_bank_if;
    import csr_counter_pkg::*;

    logic        csr_valid;
    logic [11:0] csr_addr;
    csr_op_e     csr_op;
    logic [31:0] csr_wdata;
    logic        csr_ready;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_valid, csr_addr, csr_op, csr_wdata,
        input  csr_ready, csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_valid, csr_addr, csr_op, csr_wdata,
        output csr_ready, csr_rdata, csr_illegal
    );

endinterface

// File: rtl/csr_counter_slice.sv
// ----------------------------------------------------------------------------
// csr_counter_slice
// One CNT_W-bit event counter with a 32-bit half-selected write port.
//   clk, rst   : clock, synchronous active-high reset
//   i_inc      : count one event this cycle
//   i_inhibit  : hold the current value (suppresses i_inc)
//   i_wr_en    : write the selected half with i_wdata (beats the increment)
//   i_wr_hi    : 1 selects bits [63:32], 0 selects bits [31:0]
//   i_wdata    : 32-bit write data
//   o_value    : current counter value
// ----------------------------------------------------------------------------
module csr_counter_slice #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_inhibit,
    input  logic             i_wr_en,
    input  logic             i_wr_hi,
    input  logic [31:0]      i_wdata,
    output logic [CNT_W-1:0] o_value
);

    logic [CNT_W-1:0] r_count;
    logic [63:0]      w_cur64;
    logic [63:0]      w_wr64;

    // The write is merged in a 64-bit view so the untouched half keeps its
    // old value; for CNT_W==32 the high half falls off on truncation, which
    // is how a high-half write gets discarded.
    always_comb begin
        w_cur64 = 64'(r_count);
        w_wr64  = w_cur64;
        if (i_wr_hi) begin
            w_wr64[63:32] = i_wdata;
        end else begin
            w_wr64[31:0]  = i_wdata;
        end
    end

    // A write replaces that cycle's increment entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_wr_en) begin
            r_count <= w_wr64[CNT_W-1:0];
        end else if (i_inc && !i_inhibit) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_value = r_count;

endmodule

// File: rtl/csr_counter_bank.sv
// ----------------------------------------------------------------------------
// csr_counter_bank
// cycle, time, instret and N_HPM event counters with machine-mode
// CSRRW/CSRRS/CSRRC access, per-counter inhibit and a time prescaler.
//   clk, rst      : clock, synchronous active-high reset
//   i_inst_retire : one instruction retired this cycle
//   i_hpm_event   : bit i increments hpmcounter i this cycle
//   bus           : CSR request/response channel (slave side)
// Counter slice index: 0 = cycle, 1 = instret, 2+i = hpmcounter i.
// ----------------------------------------------------------------------------
module csr_counter_bank
    import csr_counter_pkg::*;
#(
    parameter int CNT_W    = 64,
    parameter int N_HPM    = 4,
    parameter int TIME_DIV = 100
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_inst_retire,
    input  logic [(N_HPM > 0 ? N_HPM : 1)-1:0]   i_hpm_event,
    csr_counter_bank_if.slave                    bus
);

    localparam int NCNT  = 2 + N_HPM;
    localparam int DIV_W = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [31:0] INH_MASK =
        32'h0000_0005 | (((32'h1 << N_HPM) - 32'h1) << INH_HPM_BASE);

    logic [CNT_W-1:0] w_cnt_val [NCNT];
    logic [CNT_W-1:0] r_time;
    logic [DIV_W-1:0] r_div;
    logic [31:0]      r_inhibit;
    logic             r_ready;
    logic [31:0]      r_rdata;
    logic             r_illegal;

    logic [11:0]      w_lo_addr;
    logic             w_hi;
    logic             w_user;
    logic             w_legal;
    csr_sel_e         w_kind;
    logic [5:0]       w_sel;
    logic [63:0]      w_rd64;
    logic [31:0]      w_old;
    logic [31:0]      w_new;
    logic             w_wr;

    // Address decode: fold the high-half offset away, then match the base.
    // mcountinhibit is checked first because 0x3A0 also folds onto 0x320.
    always_comb begin
        w_lo_addr = bus.csr_addr & ~CSR_HI_OFFSET;
        w_hi      = bus.csr_addr[7];
        w_user    = (bus.csr_addr[11:8] == 4'hC);
        w_legal   = 1'b0;
        w_kind    = SEL_CNT;
        w_sel     = '0;
        if (bus.csr_addr == CSR_MCOUNTINHIBIT) begin
            w_legal = 1'b1;
            w_kind  = SEL_INH;
            w_hi    = 1'b0;
        end else if (w_lo_addr == CSR_CYCLE || w_lo_addr == CSR_MCYCLE) begin
            w_legal = 1'b1;
            w_sel   = 6'd0;
        end else if (w_lo_addr == CSR_TIME) begin
            w_legal = 1'b1;
            w_kind  = SEL_TIME;
        end else if (w_lo_addr == CSR_INSTRET || w_lo_addr == CSR_MINSTRET) begin
            w_legal = 1'b1;
            w_sel   = 6'd1;
        end else if (w_lo_addr >= CSR_HPM_BASE &&
                     w_lo_addr < CSR_HPM_BASE + 12'(N_HPM)) begin
            w_legal = 1'b1;
            w_sel   = 6'(w_lo_addr - CSR_HPM_BASE + 12'd2);
        end else if (w_lo_addr >= CSR_MHPM_BASE &&
                     w_lo_addr < CSR_MHPM_BASE + 12'(N_HPM)) begin
            w_legal = 1'b1;
            w_sel   = 6'(w_lo_addr - CSR_MHPM_BASE + 12'd2);
        end
        // The 0xCxx shadows are read-only.
        if (w_user && bus.csr_op != CSR_OP_READ) begin
            w_legal = 1'b0;
        end
    end

    // Old-value mux and write-data computation; the old value is the
    // pre-edge register contents, so same-cycle increments are excluded.
    always_comb begin
        w_rd64 = '0;
        case (w_kind)
            SEL_CNT: begin
                for (int k = 0; k < NCNT; k++) begin
                    if (w_sel == 6'(k)) begin
                        w_rd64 = 64'(w_cnt_val[k]);
                    end
                end
            end
            SEL_TIME: w_rd64 = 64'(r_time);
            SEL_INH:  w_rd64 = {32'h0, r_inhibit};
            default:  w_rd64 = '0;
        endcase
        w_old = w_hi ? w_rd64[63:32] : w_rd64[31:0];
        w_new = csr_apply_op(bus.csr_op, w_old, bus.csr_wdata);
        w_wr  = bus.csr_valid && w_legal && (bus.csr_op != CSR_OP_READ) &&
                (w_kind != SEL_TIME);
    end

    for (genvar k = 0; k < NCNT; k++) begin : g_cnt
        logic w_inc;
        logic w_inh;
        if (k == 0) begin : g_cycle
            assign w_inc = 1'b1;
            assign w_inh = r_inhibit[INH_CY];
        end else if (k == 1) begin : g_instret
            assign w_inc = i_inst_retire;
            assign w_inh = r_inhibit[INH_IR];
        end else begin : g_hpm
            assign w_inc = i_hpm_event[k-2];
            assign w_inh = r_inhibit[INH_HPM_BASE + k - 2];
        end
        csr_counter_slice #(.CNT_W(CNT_W)) u_slice (
            .clk       (clk),
            .rst       (rst),
            .i_inc     (w_inc),
            .i_inhibit (w_inh),
            .i_wr_en   (w_wr && (w_kind == SEL_CNT) && (w_sel == 6'(k))),
            .i_wr_hi   (w_hi),
            .i_wdata   (w_new),
            .o_value   (w_cnt_val[k])
        );
    end

    // Time prescaler: time steps once every TIME_DIV clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_time <= '0;
        end else if (r_div == DIV_W'(TIME_DIV - 1)) begin
            r_div  <= '0;
            r_time <= r_time + CNT_W'(1);
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

    // Registered response and mcountinhibit. A request during reset is
    // dropped because the reset branch forces the response to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready   <= 1'b0;
            r_rdata   <= '0;
            r_illegal <= 1'b0;
            r_inhibit <= '0;
        end else begin
            r_ready   <= bus.csr_valid;
            r_rdata   <= (bus.csr_valid && w_legal) ? w_old : 32'h0;
            r_illegal <= bus.csr_valid && !w_legal;
            if (w_wr && w_kind == SEL_INH) begin
                r_inhibit <= w_new & INH_MASK;
            end
        end
    end

    assign bus.csr_ready   = r_ready;
    assign bus.csr_rdata   = r_rdata;
    assign bus.csr_illegal = r_illegal;

endmodule

// File: tb/tb_csr_counter_bank.sv
// ----------------------------------------------------------------------------
// tb_csr_counter_bank
// Directed bench for csr_counter_bank with CNT_W=64, N_HPM=2, TIME_DIV=4.
// Edge numbering in comments counts posedges after the reset edge.
// ----------------------------------------------------------------------------
module tb_csr_counter_bank;
    import csr_counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instRetire = 1'b0;
    logic [1:0] hpmEvent = 2'b00;
    int         testsRun = 0;
    int         testsFailed = 0;

    csr_counter_bank_if bus ();

    csr_counter_bank #(.CNT_W(64), .N_HPM(2), .TIME_DIV(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_inst_retire (instRetire),
        .i_hpm_event   (hpmEvent),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // One comparison: counted, and reported on mismatch.
    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly one posedge, then release the bus
    // just after that edge, where the registered response is visible.
    task automatic applyStimulus(input logic [11:0] addr, input csr_op_e op, input logic [31:0] wdata);
        @(negedge clk);
        bus.csr_valid = 1'b1;
        bus.csr_addr  = addr;
        bus.csr_op    = op;
        bus.csr_wdata = wdata;
        @(posedge clk);
        #1;
        bus.csr_valid = 1'b0;
        bus.csr_op    = CSR_OP_READ;
        bus.csr_wdata = 32'h0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] expRdata, input logic expIllegal);
        checkValue({tag, ".ready"}, 64'(bus.csr_ready), 64'd1);
        checkValue({tag, ".rdata"}, 64'(bus.csr_rdata), 64'(expRdata));
        checkValue({tag, ".illegal"}, 64'(bus.csr_illegal), 64'(expIllegal));
    endtask

    task automatic request(input string tag, input logic [11:0] addr, input csr_op_e op,
                           input logic [31:0] wdata, input logic [31:0] expRdata, input logic expIllegal);
        applyStimulus(addr, op, wdata);
        checkOutput(tag, expRdata, expIllegal);
    endtask

    // Leaves the bench just after the reset edge with rst released, so the
    // next posedge is edge 1.
    task automatic doReset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkValue({tag, ".rst_ready"}, 64'(bus.csr_ready), 64'd0);
        checkValue({tag, ".rst_rdata"}, 64'(bus.csr_rdata), 64'd0);
        checkValue({tag, ".rst_illegal"}, 64'(bus.csr_illegal), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        bus.csr_valid = 1'b0;
        bus.csr_addr  = 12'h0;
        bus.csr_op    = CSR_OP_READ;
        bus.csr_wdata = 32'h0;

        // Cycle counter after 10 idle clocks; ready pulses for one cycle.
        doReset("cyc");
        repeat (10) @(posedge clk);
        request("cyc_read", 12'hC00, CSR_OP_READ, 32'h0, 32'd10, 1'b0);
        @(posedge clk);
        #1;
        checkValue("cyc_ready_drop", 64'(bus.csr_ready), 64'd0);
        checkValue("cyc_rdata_idle", 64'(bus.csr_rdata), 64'd0);

        // Time: ticks at edges 4,8,12,16; read sampled at edge 18.
        doReset("time");
        repeat (17) @(posedge clk);
        request("time_lo", 12'hC01, CSR_OP_READ, 32'h0, 32'd4, 1'b0);
        request("time_hi", 12'hC81, CSR_OP_READ, 32'h0, 32'd0, 1'b0);
        request("time_write", 12'hB01, CSR_OP_RW, 32'h1, 32'd0, 1'b1);

        // Low-to-high carry after writing both halves of mcycle.
        doReset("carry");
        request("carry_wr_hi", 12'hB80, CSR_OP_RW, 32'h1, 32'h0, 1'b0);
        request("carry_wr_lo", 12'hB00, CSR_OP_RW, 32'hFFFF_FFFF, 32'h0, 1'b0);
        @(posedge clk);
        request("carry_rd_lo", 12'hC00, CSR_OP_READ, 32'h0, 32'h0, 1'b0);
        request("carry_rd_hi", 12'hC80, CSR_OP_READ, 32'h0, 32'h2, 1'b0);

        // Inhibit: CY+IR set at edge 1, effective from edge 2.
        doReset("inh");
        request("inh_rs", 12'h320, CSR_OP_RS, 32'h5, 32'h0, 1'b0);
        @(negedge clk);
        instRetire = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        instRetire = 1'b0;
        request("inh_minstret", 12'hB02, CSR_OP_READ, 32'h0, 32'd0, 1'b0);
        request("inh_mcycle", 12'hB00, CSR_OP_READ, 32'h0, 32'd1, 1'b0);
        request("inh_reg", 12'h320, CSR_OP_READ, 32'h0, 32'h5, 1'b0);
        request("inh_rc", 12'h320, CSR_OP_RC, 32'h1, 32'h5, 1'b0);
        request("inh_resume0", 12'hC00, CSR_OP_READ, 32'h0, 32'd1, 1'b0);
        request("inh_resume1", 12'hC00, CSR_OP_READ, 32'h0, 32'd2, 1'b0);
        request("inh_wr_all", 12'h320, CSR_OP_RW, 32'hFFFF_FFFF, 32'h4, 1'b0);
        request("inh_mask", 12'h320, CSR_OP_READ, 32'h0, 32'h1D, 1'b0);
        request("inh_clear", 12'h320, CSR_OP_RW, 32'h0, 32'h1D, 1'b0);
        @(negedge clk);
        instRetire = 1'b1;
        hpmEvent   = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        instRetire = 1'b0;
        hpmEvent   = 2'b00;
        request("ev_instret", 12'hC02, CSR_OP_READ, 32'h0, 32'd2, 1'b0);
        request("ev_hpm1", 12'hC04, CSR_OP_READ, 32'h0, 32'd2, 1'b0);
        request("ev_hpm0", 12'hC03, CSR_OP_READ, 32'h0, 32'd0, 1'b0);

        // Illegal accesses return 0 and change nothing.
        doReset("ill");
        request("ill_wr_user", 12'hC02, CSR_OP_RW, 32'h55, 32'h0, 1'b1);
        request("ill_hpm_range", 12'hB05, CSR_OP_READ, 32'h0, 32'h0, 1'b1);
        request("ill_unmapped", 12'h7FF, CSR_OP_READ, 32'h0, 32'h0, 1'b1);
        request("ill_instret", 12'hC02, CSR_OP_READ, 32'h0, 32'h0, 1'b0);
        request("ill_mhpm1", 12'hB04, CSR_OP_READ, 32'h0, 32'h0, 1'b0);
        request("ill_cycle", 12'hC00, CSR_OP_READ, 32'h0, 32'd5, 1'b0);

        // Request during reset is dropped; mcycle counts from 0.
        @(negedge clk);
        rst           = 1'b1;
        bus.csr_valid = 1'b1;
        bus.csr_addr  = 12'hB00;
        bus.csr_op    = CSR_OP_RW;
        bus.csr_wdata = 32'h1234;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.csr_valid = 1'b0;
        bus.csr_op    = CSR_OP_READ;
        checkValue("rstreq_ready", 64'(bus.csr_ready), 64'd0);
        @(posedge clk);
        #1;
        checkValue("rstreq_ready_next", 64'(bus.csr_ready), 64'd0);
        request("rstreq_mcycle", 12'hB00, CSR_OP_READ, 32'h0, 32'd1, 1'b0);
        request("rstreq_mcycleh", 12'hB80, CSR_OP_READ, 32'h0, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
